// File: rtl/sram_bus_pkg.sv
// sram_bus_pkg: shared state encoding and sizing helpers for the SPRAM
// arbiter and its write FIFO.
package sram_bus_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITE     = 2'd1;
    localparam logic [1:0] ST_READ_WAIT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_WRITE     = ST_WRITE,
        S_READ_WAIT = ST_READ_WAIT
    } state_e;

    // ceil(log2(value)), never less than 1 so a single-entry range still
    // gets a usable index width.
    function automatic int clogb2(input int value);
        int v;
        int result;
        v = value - 1;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                result = result + 1;
                v = v >> 1;
            end
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_write_fifo.sv
// sram_write_fifo: synchronous FIFO buffering {address, data} writes while
// the SPRAM is busy. A push while full is ignored; the parent flags it.
module sram_write_fifo
    import sram_bus_pkg::*;
#(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = clogb2(DEPTH);

    logic [WIDTH-1:0] store_mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == (PW + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = store_mem[rd_ptr_q];

    // pointer and occupancy update; DEPTH is a power of two so pointers wrap
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end

    // occupancy registers, cleared by reset so stored entries are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            store_mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SPRAM between a buffered write port
// and NUM_READERS read channels. Writes and reads alternate 1:1 while both
// are pending. Build macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin read
// arbitration; without it the lowest-numbered eligible channel wins.
// The SPRAM samples the registered address, so READ_LATENCY must be at
// least 2 for read_data to reflect the granted address.
module sram_arbiter
    import sram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_READERS  = 10,
    parameter int WFIFO_DEPTH  = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_WIDTH-1:0]             write_address,
    input  logic [DATA_WIDTH-1:0]             write_data,
    input  logic                              write_strobe,
    output logic                              write_full,
    output logic                              write_overflow,
    input  logic [NUM_READERS-1:0]            read_requests,
    input  logic [NUM_READERS*ADDR_WIDTH-1:0] read_addresses,
    output logic [NUM_READERS-1:0]            read_finished_strobes,
    output logic [DATA_WIDTH-1:0]             read_data,
    output logic                              busy
);

    localparam int         IDX_W    = clogb2(NUM_READERS);
    localparam int         FIFO_W   = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

    localparam logic       SPRAM_CHIPSELECT = 1'b1;
    localparam logic [3:0] SPRAM_MASKWREN   = 4'b1111;
    localparam logic       SPRAM_STANDBY    = 1'b0;
    localparam logic       SPRAM_SLEEP      = 1'b0;
    localparam logic       SPRAM_POWEROFF   = 1'b1;

    state_e                  state_q, state_d;
    logic                    last_read_q, last_read_d;
    logic [1:0]              rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
    logic [NUM_READERS-1:0]  strobes_q, strobes_d;
    logic [NUM_READERS-1:0]  mask_q, mask_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic                    overflow_q, overflow_d;
    logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0]   sram_wdata_q, sram_wdata_d;
    logic                    sram_wren_q, sram_wren_d;
    logic [DATA_WIDTH-1:0]   spram_dataout;
    logic [DATA_WIDTH-1:0]   spram_mem [2**ADDR_WIDTH];

    logic [NUM_READERS-1:0]  eligible;
    logic                    any_elig;
    logic [IDX_W-1:0]        grant_sel;
    logic [ADDR_WIDTH-1:0]   grant_addr;
    logic                    fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0]       fifo_head;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic                    grant_hit;
    int                      rr_cand;
`endif

    sram_write_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (write_strobe),
        .push_data ({write_address, write_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign eligible              = read_requests & ~mask_q;
    assign any_elig              = |eligible;
    assign grant_addr            = read_addresses[int'(grant_sel) * ADDR_WIDTH +: ADDR_WIDTH];
    assign write_full            = fifo_full;
    assign write_overflow        = overflow_q;
    assign read_finished_strobes = strobes_q;
    assign read_data             = read_data_q;
    assign busy                  = (state_q != S_IDLE) | ~fifo_empty;

    // choose which eligible read channel would be served next
    always_comb begin
        grant_sel = '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        grant_hit = 1'b0;
        rr_cand   = 0;
        for (int k = 0; k < NUM_READERS; k++) begin
            rr_cand = int'(ptr_q) + 1 + k;
            if (rr_cand >= NUM_READERS) begin
                rr_cand = rr_cand - NUM_READERS;
            end
            if (!grant_hit && eligible[rr_cand]) begin
                grant_hit = 1'b1;
                grant_sel = IDX_W'(rr_cand);
            end
        end
`else
        for (int k = NUM_READERS - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                grant_sel = IDX_W'(k);
            end
        end
`endif
    end

    // next-state and registered-output logic of the access sequencer
    always_comb begin
        state_d      = state_q;
        last_read_d  = last_read_q;
        rd_cnt_d     = rd_cnt_q;
        grant_idx_d  = grant_idx_q;
        strobes_d    = '0;
        read_data_d  = read_data_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_wren_d  = 1'b0;
        fifo_pop     = 1'b0;
        overflow_d   = overflow_q | (write_strobe & fifo_full);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && (last_read_q || !any_elig)) begin
                    fifo_pop     = 1'b1;
                    sram_addr_d  = fifo_head[FIFO_W-1 -: ADDR_WIDTH];
                    sram_wdata_d = fifo_head[DATA_WIDTH-1:0];
                    sram_wren_d  = 1'b1;
                    last_read_d  = 1'b0;
                    state_d      = S_WRITE;
                end else if (any_elig) begin
                    grant_idx_d  = grant_sel;
                    sram_addr_d  = grant_addr;
                    last_read_d  = 1'b1;
                    rd_cnt_d     = '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    ptr_d        = grant_sel;
`endif
                    state_d      = S_READ_WAIT;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_READ_WAIT: begin
                if (rd_cnt_q == LAST_CNT) begin
                    read_data_d            = spram_dataout;
                    strobes_d[grant_idx_q] = 1'b1;
                    state_d                = S_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // the channel strobed this cycle may still show its request once more
        mask_d = strobes_d;
    end

    // sequencer state and outputs; a reset abandons any in-flight read
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_read_q  <= 1'b1;
            rd_cnt_q     <= '0;
            grant_idx_q  <= '0;
            strobes_q    <= '0;
            mask_q       <= '0;
            read_data_q  <= '0;
            overflow_q   <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_wren_q  <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            ptr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_read_q  <= last_read_d;
            rd_cnt_q     <= rd_cnt_d;
            grant_idx_q  <= grant_idx_d;
            strobes_q    <= strobes_d;
            mask_q       <= mask_d;
            read_data_q  <= read_data_d;
            overflow_q   <= overflow_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_wren_q  <= sram_wren_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    // single-port SPRAM: registered read data, word write when enabled
    always_ff @(posedge clk) begin
        if (SPRAM_CHIPSELECT && !SPRAM_STANDBY && !SPRAM_SLEEP && SPRAM_POWEROFF) begin
            if (sram_wren_q && (&SPRAM_MASKWREN)) begin
                spram_mem[sram_addr_q] <= sram_wdata_q;
            end
            spram_dataout <= spram_mem[sram_addr_q];
        end
    end

endmodule
